// File: rtl/i2c_txn_arbiter_if.sv
// Bundle of requester handshake and I2C-master control signals shared by the arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/bus-master side.
interface i2c_txn_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      m_en;
    logic                      m_rw;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic                      m_done;
    logic [DATA_W-1:0]         m_rdata;
    logic                      busy;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, m_done, m_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               m_en, m_rw, m_addr, m_wdata, busy
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, m_done, m_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               m_en, m_rw, m_addr, m_wdata, busy
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ requesters, one transaction
// at a time, with a WAIT-state timeout so a hung bus cannot lock requesters out.
module i2c_txn_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    i2c_txn_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_req_ready;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_m_en;
    logic               r_m_rw;
    logic [ADDR_W-1:0]  r_m_addr;
    logic [DATA_W-1:0]  r_m_wdata;
    logic               r_busy;

    logic               w_found;
    logic [IDX_W-1:0]   w_grant;
    logic [IDX_W-1:0]   w_idx;

    // Search upward from the requester after the last winner, wrapping, so the last winner goes last.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
            r_grant     <= '0;
            r_cnt       <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_m_en      <= 1'b0;
            r_m_rw      <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_grant;
                        r_m_rw      <= bus.req_rw[w_grant];
                        r_m_addr    <= bus.req_addr[int'(w_grant)*ADDR_W +: ADDR_W];
                        r_m_wdata   <= bus.req_wdata[int'(w_grant)*DATA_W +: DATA_W];
                        r_req_ready <= ONE_HOT0 << w_grant;
                        r_m_en      <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the final timeout cycle still counts as success.
                    if (bus.m_done) begin
                        r_rsp_rdata <= r_m_rw ? bus.m_rdata : '0;
                        r_rsp_err   <= 1'b0;
                        r_m_en      <= 1'b0;
                        r_rsp_valid <= ONE_HOT0 << r_grant;
                        r_state     <= S_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_m_en      <= 1'b0;
                        r_rsp_valid <= ONE_HOT0 << r_grant;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_rr_ptr <= r_grant;
                    r_state  <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Level-sensitive done must fall before the next transaction may start.
                    if (!bus.m_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_m_en  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.m_en      = r_m_en;
    assign bus.m_rw      = r_m_rw;
    assign bus.m_addr    = r_m_addr;
    assign bus.m_wdata   = r_m_wdata;
    assign bus.busy      = r_busy;
endmodule
